l1_i_fetch_unit: RTL
====================

// Module: l1_i_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the L1 I-cache controller.
//  - Holds the PC and issues one line lookup at a time (tag/index/read pulse).
//  - Holds the lookup stable while the controller stalls; captures the selected word from the L1I data array.
//  - Feeds a small instruction queue toward decode.
//  - Handles branch redirects and fence.i flush requests.
// PARAMETERS
//  TNUM      21            tag width, PC[31 -: TNUM]
//  INUM      5             index width, PC[31-TNUM -: INUM]
//  OFFW      4             word-in-line select width, PC[OFFW+1:2]; TNUM+INUM+OFFW+2 must equal 32
//  QDEPTH    4             instruction queue entries, power of 2, >=2
//  RESET_PC  32'h0000_0000 PC after reset; bits [1:0] must be 0
// PORTS
//  clk            in   1     clock
//  nrst           in   1     reset, asynchronous, active-low
//  tag_o          out  TNUM  lookup tag to controller
//  index_o        out  INUM  lookup index to controller
//  read_o         out  1     one-cycle lookup request
//  flush_o        out  1     one-cycle invalidate-all pulse to controller
//  stall_i        in   1     controller busy (high from the cycle after read_o until lookup done)
//  miss_i         in   1     controller miss pulse
//  word_o         out  OFFW  word select to data array
//  instr_i        in   32    selected instruction word from data array
//  redirect_i     in   1     branch/exception redirect, single cycle
//  redirect_pc_i  in   32    redirect target; bits [1:0] ignored, forced 0
//  fence_i_i      in   1     fence.i request, single cycle
//  fence_busy_o   out  1     fence pending or in progress
//  inst_valid_o   out  1     queue head valid
//  inst_o         out  32    queue head instruction
//  inst_pc_o      out  32    queue head PC
//  inst_ready_i   in   1     decode accepts head (pop when valid&ready)
// BEHAVIOUR
//  Reset values:
//  - pc = RESET_PC; all outputs 0 except tag_o/index_o/word_o, which are slices of the PC.
//  - queue empty; FSM F_IDLE; discard = 0; fence_pend = 0.
//  - Reset mid-operation aborts everything; the controller shares nrst.
//  FSM states: F_IDLE, F_REQ, F_WAIT, F_FLUSH.
//  - F_IDLE -> F_FLUSH when fence_pend & stall_i==0 (fence has priority over fetch).
//  - F_IDLE -> F_REQ when count < QDEPTH & stall_i==0.
//  - F_REQ: read_o=1 for exactly this cycle; -> F_WAIT. stall_i is still 0 in F_REQ and is ignored.
//  - F_WAIT: hold tag/index/word. On the first cycle with stall_i==0, instr_i is valid:
//    - push {pc, instr_i} and pc += 4, unless discard;
//    - clear discard; -> F_IDLE.
//  - F_FLUSH: flush_o=1 for one cycle; clear fence_pend; -> F_IDLE.
//  Outstanding lookups and latency:
//  - At most one outstanding lookup; tag_o/index_o/word_o are driven from pc and stable from F_REQ through F_WAIT.
//  - Hit latency, read_o to push: 4 cycles (REQ, controller COMPARE x2, completion).
//  - A miss extends F_WAIT until the controller refills; no special handling is needed.
//  Redirect:
//  - pc <= redirect_pc_i & ~3 and the queue is cleared in the same cycle.
//  - A simultaneous pop is ignored.
//  - In F_REQ/F_WAIT, set discard; the in-flight lookup completes and its word is dropped.
//  - Redirect on the completion cycle: the completing word is dropped and pc takes the redirect target.
//  fence.i:
//  - Sets fence_pend; fence_busy_o = fence_pend | (state==F_FLUSH).
//  - A redirect and fence.i in the same cycle are both applied.
//  Queue:
//  - count cannot exceed QDEPTH because a request is issued only when count < QDEPTH.
//  - Push and pop in the same cycle leave count unchanged; pc wraps modulo 2^32.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//  - Extra outputs fetch_cnt_o[31:0] (pushes) and miss_cnt_o[31:0] (miss_i pulses).
//  - Both counters wrap and are cleared by nrst.
//  Undefined: no ports and no counter logic.
// STRUCTURE
//  Package l1_i_pkg:
//  - F_* state encodings;
//  - ADDR_W=32, default TNUM/INUM/OFFW;
//  - pc slicing constants shared with the controller and data array.
//  Sub-module fetch_queue: synchronous FIFO of {pc,instr}, with QDEPTH, push/pop/clear, count.
// TESTING
//  1. Reset, stall_i driven as a 2-cycle hit model:
//     - read_o at cycle 1 with tag/index of 0x0;
//     - push pc=0x0 at cycle 4;
//     - next read_o with pc=0x4.
//  2. Miss: stall_i held 20 cycles, miss_i pulsed:
//     - tag/index held constant throughout;
//     - single push;
//     - perf build: miss_cnt_o=1.
//  3. inst_ready_i=0, QDEPTH=4: exactly 4 pushes then no read_o; one pop -> exactly one new read_o.
//  4. redirect_i to 0x1003 during F_WAIT:
//     - in-flight word dropped, queue empty;
//     - next read_o uses pc=0x1000.
//  5. fence_i_i during F_WAIT:
//     - flush_o pulses once after completion, with stall_i==0;
//     - fence_busy_o falls the following cycle;
//     - fetch resumes.
//  6. nrst asserted mid-F_WAIT: all outputs return to reset values asynchronously; pc=RESET_PC.

Source files
------------

// File: rtl/l1_i_pkg.sv
// Shared definitions for the L1 instruction fetch path: state encodings, default
// address split and the queue entry layout used by the fetch unit and its queue.
package l1_i_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TNUM_DEF = 21;
    localparam int unsigned INUM_DEF = 5;
    localparam int unsigned OFFW_DEF = 4;

    // PC field positions, shared with the controller and data array
    localparam int unsigned TAG_LSB  = ADDR_W - TNUM_DEF;
    localparam int unsigned IDX_LSB  = TAG_LSB - INUM_DEF;
    localparam int unsigned WORD_LSB = 2;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_REQ   = 2'd1,
        F_WAIT  = 2'd2,
        F_FLUSH = 2'd3
    } f_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] instr;
    } fq_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/l1_i_fetch_unit_if.sv
// Fetch unit bus: lookup/flush toward the I-cache controller, redirect/fence from
// the core, and the instruction queue head toward decode.
interface l1_i_fetch_unit_if
    import l1_i_pkg::*;
#(
    parameter int unsigned TNUM = TNUM_DEF,
    parameter int unsigned INUM = INUM_DEF,
    parameter int unsigned OFFW = OFFW_DEF
);
    logic [TNUM-1:0]   tag_o;
    logic [INUM-1:0]   index_o;
    logic              read_o;
    logic              flush_o;
    logic              stall_i;
    logic              miss_i;
    logic [OFFW-1:0]   word_o;
    logic [ADDR_W-1:0] instr_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              fence_i_i;
    logic              fence_busy_o;
    logic              inst_valid_o;
    logic [ADDR_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_ready_i;

    modport master (
        output tag_o, index_o, read_o, flush_o, word_o, fence_busy_o,
               inst_valid_o, inst_o, inst_pc_o,
        input  stall_i, miss_i, instr_i, redirect_i, redirect_pc_i,
               fence_i_i, inst_ready_i
    );

    modport slave (
        input  tag_o, index_o, read_o, flush_o, word_o, fence_busy_o,
               inst_valid_o, inst_o, inst_pc_o,
        output stall_i, miss_i, instr_i, redirect_i, redirect_pc_i,
               fence_i_i, inst_ready_i
    );

endinterface

// File: rtl/l1_i_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} between fetch and decode; clear empties it
// in one cycle and takes priority over push/pop.
module fetch_queue
    import l1_i_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fq_entry_t                din,
    output fq_entry_t                dout,
    output logic [$clog2(QDEPTH):0]  count
);
    localparam int unsigned AW = $clog2(QDEPTH);

    fq_entry_t        mem [QDEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/l1_i_fetch_unit.sv
// Instruction fetch stage in front of the L1 I-cache controller: one lookup at a time,
// redirect/fence.i handling, instruction queue to decode. Optional FETCH_PERF_CNT_EN.
module l1_i_fetch_unit
    import l1_i_pkg::*;
#(
    parameter int unsigned       TNUM     = TNUM_DEF,
    parameter int unsigned       INUM     = INUM_DEF,
    parameter int unsigned       OFFW     = OFFW_DEF,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               nrst,
    l1_i_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);
    localparam int unsigned CW     = $clog2(QDEPTH);
    localparam logic [CW:0] Q_FULL = (CW+1)'(QDEPTH);

    f_state_e          state, state_nxt;
    logic [ADDR_W-1:0] pc, lk_pc, addr, redir_pc;
    logic              discard, fence_pend;
    logic              read_req, flush_req, lookup_done;
    logic              push, pop;
    logic [CW:0]       count;
    fq_entry_t         push_entry, head;

    assign redir_pc = word_align(bus.redirect_pc_i);

    always_comb begin
        state_nxt   = state;
        read_req    = 1'b0;
        flush_req   = 1'b0;
        lookup_done = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (fence_pend && !bus.stall_i)
                    state_nxt = F_FLUSH;
                else if (count < Q_FULL && !bus.stall_i)
                    state_nxt = F_REQ;
            end
            F_REQ: begin
                read_req  = 1'b1;
                state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (!bus.stall_i) begin
                    lookup_done = 1'b1;
                    state_nxt   = F_IDLE;
                end
            end
            F_FLUSH: begin
                flush_req = 1'b1;
                state_nxt = F_IDLE;
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    // A redirect on the completion cycle drops the word just like a pending discard
    assign push = lookup_done && !discard && !bus.redirect_i;
    assign pop  = bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= F_IDLE;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            fence_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.redirect_i) pc <= redir_pc;
            else if (push)      pc <= pc + 32'd4;
            if (lookup_done)
                discard <= 1'b0;
            else if (bus.redirect_i && (state == F_REQ || state == F_WAIT))
                discard <= 1'b1;
            if (bus.fence_i_i)         fence_pend <= 1'b1;
            else if (state == F_FLUSH) fence_pend <= 1'b0;
        end
    end

    // Lookup address is frozen at issue so a redirect cannot disturb a lookup in flight
    always_ff @(posedge clk) begin
        if (state == F_IDLE && state_nxt == F_REQ)
            lk_pc <= bus.redirect_i ? redir_pc : pc;
    end

    assign addr = (state == F_REQ || state == F_WAIT) ? lk_pc : pc;

    assign push_entry = '{pc: lk_pc, instr: bus.instr_i};

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .clear (bus.redirect_i),
        .din   (push_entry),
        .dout  (head),
        .count (count)
    );

    assign bus.tag_o        = addr[ADDR_W-1 -: TNUM];
    assign bus.index_o      = addr[ADDR_W-1-TNUM -: INUM];
    assign bus.word_o       = addr[WORD_LSB +: OFFW];
    assign bus.read_o       = read_req;
    assign bus.flush_o      = flush_req;
    assign bus.fence_busy_o = fence_pend || (state == F_FLUSH);
    assign bus.inst_valid_o = (count != '0);
    assign bus.inst_o       = bus.inst_valid_o ? head.instr : '0;
    assign bus.inst_pc_o    = bus.inst_valid_o ? head.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_cnt_o <= '0;
            miss_cnt_o  <= '0;
        end else begin
            if (push)       fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (bus.miss_i) miss_cnt_o  <= miss_cnt_o + 32'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^addr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], bus.miss_i};
`endif

endmodule
